// File: rtl/jtdd_sndcmd.sv
// Main-CPU side of the sound command channel: queues CPU writes and hands them to the sound CPU one
// at a time (latch + irq pulse, hold until ack). Optional ack timeout: define JTDD_SNDCMD_TIMEOUT_EN.
module jtdd_sndcmd #(
  parameter int unsigned AW      = 2,
  parameter int unsigned IRQ_LEN = 16,
  parameter int unsigned TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cen,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       snd_ack,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       full,
  output logic       busy,
  output logic       ovf
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned PW    = $clog2(IRQ_LEN);

  typedef enum logic [1:0] {StIdle, StPulse, StWait} state_e;

  state_e          state;
  logic [7:0]      mem [Depth];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [PW-1:0]   pulse_cnt;
  logic            ack_seen;
  logic            wr_req, push, pop, to_done;

  assign full   = (count == (AW+1)'(Depth));
  assign busy   = (state != StIdle) || (count != '0);
  assign wr_req = wr && cpu_cen;
  assign pop    = (state == StIdle) && (count != '0);
  // A pop on the same edge frees a slot, so a write into a full FIFO is still accepted.
  assign push   = wr_req && (!full || pop);

`ifdef JTDD_SNDCMD_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // The give-up edge is the one on which the counter turns all-ones.
  assign to_done = (state == StWait) && (&to_cnt[TO_W-1:1]) && !to_cnt[0];

  always_ff @(posedge clk) begin
    if (rst || pop) begin
      to_cnt <= '0;
    end else if (state != StIdle) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_to_w;
  assign unused_to_w = ^TO_W;
  assign to_done     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pulse_cnt <= '0;
      ack_seen  <= 1'b0;
      snd_latch <= 8'h00;
      snd_irq   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if ((wr_req && full && !pop) || to_done) begin
        ovf <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (pop) begin
            snd_latch <= mem[rd_ptr];
            snd_irq   <= 1'b1;
            pulse_cnt <= PW'(IRQ_LEN - 1);
            ack_seen  <= 1'b0;
            state     <= StPulse;
          end
        end
        StPulse: begin
          // An early ack is remembered so WAIT can leave straight away.
          if (snd_ack) begin
            ack_seen <= 1'b1;
          end
          if (pulse_cnt == '0) begin
            snd_irq <= 1'b0;
            state   <= StWait;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        StWait: begin
          if (snd_ack || ack_seen || to_done) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_sndcmd.sv
// Self-checking bench for jtdd_sndcmd: scoreboard of written bytes checked against each irq pulse,
// plus flag checks for reset, burst/overflow, early ack, push/pop while full and reset mid-pulse.
module tb_jtdd_sndcmd;

  localparam int IrqLen = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_cen = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       snd_ack = 1'b0;
  logic [7:0] snd_latch;
  logic       snd_irq, full, busy, ovf;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb [$];
  logic       irq_prev = 1'b0;
  int         width = 0;

  jtdd_sndcmd #(.AW(2), .IRQ_LEN(IrqLen), .TO_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cen   (cpu_cen),
    .wr        (wr),
    .din       (din),
    .snd_ack   (snd_ack),
    .snd_latch (snd_latch),
    .snd_irq   (snd_irq),
    .full      (full),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: compares each new command against the scoreboard and measures pulse width.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      irq_prev = 1'b0;
      width    = 0;
      sb.delete();
    end else begin
      if (snd_irq && !irq_prev) begin
        check_eq("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          check_eq("latch_data", 32'(snd_latch), 32'(sb.pop_front()));
        end
        width = 1;
      end else if (snd_irq) begin
        width++;
      end else if (irq_prev) begin
        check_eq("irq_width", width, IrqLen);
      end
      irq_prev = snd_irq;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic burst(input logic [7:0] base, input int n, input int n_acc);
    for (int i = 0; i < n; i++) begin
      din     = base + 8'(i);
      wr      = 1'b1;
      cpu_cen = 1'b1;
      if (i < n_acc) sb.push_back(din);
      cyc();
    end
    wr = 1'b0;
  endtask

  task automatic wait_irq(input logic lvl, input string tag);
    for (int i = 0; i < 400 && snd_irq !== lvl; i++) cyc();
    check_eq(tag, 32'(snd_irq), 32'(lvl));
  endtask

  task automatic ack_pulse();
    snd_ack = 1'b1;
    cyc();
    snd_ack = 1'b0;
  endtask

  task automatic drain_one();
    wait_irq(1'b1, "drain_rise");
    wait_irq(1'b0, "drain_fall");
    ack_pulse();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    check_eq("rst_latch", 32'(snd_latch), 32'h00);
    check_eq("rst_irq", 32'(snd_irq), 0);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ovf", 32'(ovf), 0);

    // Writes without cpu_cen are ignored
    wr = 1'b1; cpu_cen = 1'b0; din = 8'hff;
    repeat (3) cyc();
    wr = 1'b0;
    check_eq("cen_gate_busy", 32'(busy), 0);

    // Single command
    burst(8'h5a, 1, 1);
    check_eq("single_busy", 32'(busy), 1);
    check_eq("single_irq_lat", 32'(snd_irq), 0);
    cyc();
    check_eq("single_irq", 32'(snd_irq), 1);
    check_eq("single_latch", 32'(snd_latch), 32'h5a);
    wait_irq(1'b0, "single_fall");
    repeat (10) cyc();
    check_eq("single_busy_wait", 32'(busy), 1);
    check_eq("single_latch_hold", 32'(snd_latch), 32'h5a);
    ack_pulse();
    check_eq("single_busy_done", 32'(busy), 0);

    // Burst of five fills the FIFO, sixth is dropped
    burst(8'ha1, 5, 5);
    check_eq("burst_full", 32'(full), 1);
    check_eq("burst_ovf0", 32'(ovf), 0);
    burst(8'ha6, 1, 0);
    check_eq("burst_ovf1", 32'(ovf), 1);
    check_eq("burst_full2", 32'(full), 1);
    repeat (5) drain_one();
    check_eq("burst_busy_done", 32'(busy), 0);
    check_eq("burst_sb_empty", 32'(sb.size()), 0);
    check_eq("burst_ovf_sticky", 32'(ovf), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("rst_ovf_clear", 32'(ovf), 0);

    // Early ack during PULSE: next irq rises two clocks after the fall
    burst(8'hb1, 2, 2);
    wait_irq(1'b1, "early_rise");
    cyc();
    cyc();
    ack_pulse();
    wait_irq(1'b0, "early_fall");
    cyc();
    check_eq("early_gap1", 32'(snd_irq), 0);
    cyc();
    check_eq("early_gap2", 32'(snd_irq), 1);
    wait_irq(1'b0, "early_fall2");
    ack_pulse();
    check_eq("early_busy_done", 32'(busy), 0);

    // Push and pop on the same edge while full
    burst(8'hc1, 5, 5);
    wait_irq(1'b0, "pp_fall");
    check_eq("pp_full_before", 32'(full), 1);
    snd_ack = 1'b1;
    cyc();
    snd_ack = 1'b0;
    wr = 1'b1; cpu_cen = 1'b1; din = 8'hc6;
    sb.push_back(din);
    cyc();
    wr = 1'b0;
    check_eq("pp_full_after", 32'(full), 1);
    check_eq("pp_ovf", 32'(ovf), 0);
    repeat (5) drain_one();
    check_eq("pp_busy_done", 32'(busy), 0);
    check_eq("pp_sb_empty", 32'(sb.size()), 0);

    // Reset in the middle of a pulse with entries queued
    burst(8'hd1, 4, 4);
    wait_irq(1'b1, "rstmid_rise");
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    check_eq("rstmid_irq", 32'(snd_irq), 0);
    check_eq("rstmid_busy", 32'(busy), 0);
    check_eq("rstmid_full", 32'(full), 0);
    check_eq("rstmid_latch", 32'(snd_latch), 32'h00);
    rst = 1'b0;
    repeat (40) cyc();
    check_eq("rstmid_no_stale_irq", 32'(snd_irq), 0);
    check_eq("rstmid_no_stale_latch", 32'(snd_latch), 32'h00);
    check_eq("rstmid_idle", 32'(busy), 0);

    // Without an ack the channel holds in WAIT
    burst(8'he1, 1, 1);
    wait_irq(1'b1, "hold_rise");
    wait_irq(1'b0, "hold_fall");
    repeat (300) cyc();
    check_eq("hold_busy", 32'(busy), 1);
    check_eq("hold_ovf", 32'(ovf), 0);
    ack_pulse();
    check_eq("hold_busy_done", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
